// File: rtl/archie_upload_pkg.sv
// ----------------------------------------------------------------------------
// archie_upload_pkg
// Shared types and constants for the SDRAM upload path (archie_ram_uploader).
//   state_t         : upload read-master FSM states
//   WB_CTI_CLASSIC  : wishbone cycle type for single classic reads
//   WB_SEL_WORD     : byte-select for full 32-bit word reads
// ----------------------------------------------------------------------------
package archie_upload_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEMAND,
        ST_PREFETCH,
        ST_PF_REDIRECT
    } state_t;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [3:0] WB_SEL_WORD    = 4'hF;

endpackage

// File: rtl/archie_ram_uploader.sv
// ----------------------------------------------------------------------------
// archie_ram_uploader
// Wishbone read master streaming SDRAM words to the HPS over the ioctl upload
// channel. A one-word prefetch buffer hides SDRAM latency on sequential reads.
//
// Ports
//   clk_sys, reset        : system clock, synchronous active-high reset
//   ioctl_upload          : upload session active (level)
//   ioctl_rd, ioctl_addr  : one-cycle read request, word-aligned byte address
//   ioctl_din, ioctl_wait : read data to HPS, hold-off request
//   upload_active         : bus-mux select (session or wishbone cycle live)
//   wb_*                  : classic wishbone read master port
//   timeout_err           : sticky, set when a read gets no ack in time
// ----------------------------------------------------------------------------
module archie_ram_uploader
    import archie_upload_pkg::*;
#(
    parameter bit          PREFETCH = 1'b1,
    parameter int unsigned TIMEOUT  = 1023,
    parameter logic [31:0] FILL     = 32'hFFFF_FFFF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [31:0] ioctl_din,
    output logic        ioctl_wait,
    output logic        upload_active,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [2:0]  wb_cti,
    output logic [25:0] wb_adr,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    output logic        timeout_err
);

    state_t       r_state;
    logic [31:0]  r_buf_data;
    logic [23:2]  r_buf_adr;
    logic         r_buf_vld;
    logic [23:2]  r_adr;       // address of the current/next wishbone cycle
    logic [23:2]  r_req_adr;   // request latched while a prefetch drains
    logic         r_stb;
    logic         r_want;      // HPS is waiting on the in-flight prefetch word
    logic         r_upload_q;
    logic         r_active;
    logic         r_terr;
    logic [31:0]  r_din;
    logic         r_wait;
    logic [31:0]  r_tcnt;

    logic [23:2]  w_rd_adr;
    logic         w_rd;
    logic         w_hit;
    logic         w_ack;
    logic         w_tmo;
    logic         w_done;
    logic         w_up_rise;
    logic         w_unused;

    assign w_rd_adr  = ioctl_addr[23:2];
    assign w_rd      = ioctl_rd & ioctl_upload;
    assign w_hit     = r_buf_vld && (r_buf_adr == w_rd_adr);
    assign w_ack     = r_stb & wb_ack;
    assign w_tmo     = (TIMEOUT != 0) && r_stb && !wb_ack && (r_tcnt == TIMEOUT - 1);
    assign w_done    = w_ack | w_tmo;
    assign w_up_rise = ioctl_upload & ~r_upload_q;
    assign w_unused  = ^{ioctl_addr[24], ioctl_addr[1:0]};

    // In DEMAND/PREFETCH a low r_stb is the one-cycle gap before the next
    // cycle: the state is entered with stb low and raises it a cycle later.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // NOTE: the buffer word is reset too; r_buf_vld alone would guard
            // it, but a clean reset state keeps ioctl_din deterministic.
            r_state    <= ST_IDLE;
            r_buf_data <= '0;
            r_buf_adr  <= '0;
            r_buf_vld  <= 1'b0;
            r_adr      <= '0;
            r_req_adr  <= '0;
            r_stb      <= 1'b0;
            r_want     <= 1'b0;
            r_upload_q <= 1'b0;
            r_active   <= 1'b0;
            r_terr     <= 1'b0;
            r_din      <= '0;
            r_wait     <= 1'b0;
            r_tcnt     <= '0;
        end else begin
            // NOTE: later non-blocking writes in this block override earlier
            // ones, so the FSM case below can re-raise r_stb after the gap.
            r_upload_q <= ioctl_upload;
            r_active   <= ioctl_upload || (r_state != ST_IDLE);
            r_tcnt     <= (r_stb && !w_done) ? r_tcnt + 1 : '0;
            if (w_up_rise) r_terr <= 1'b0;
            if (w_done)    r_stb  <= 1'b0;
            if (w_tmo)     r_terr <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_rd) begin
                        if (w_hit) begin
                            r_din <= r_buf_data;
                            if (PREFETCH) begin
                                r_adr   <= r_buf_adr + 22'd1;
                                r_stb   <= 1'b1;
                                r_state <= ST_PREFETCH;
                            end
                        end else begin
                            r_wait  <= 1'b1;
                            r_adr   <= w_rd_adr;
                            r_stb   <= 1'b1;
                            r_state <= ST_DEMAND;
                        end
                    end
                end

                ST_DEMAND: begin
                    if (!r_stb) begin
                        if (!ioctl_upload) begin
                            r_wait  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_stb <= 1'b1;
                        end
                    end else if (w_done) begin
                        r_wait <= 1'b0;
                        if (!ioctl_upload) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_din <= w_ack ? wb_dat_i : FILL;
                            if (PREFETCH && w_ack) begin
                                r_adr   <= r_adr + 22'd1;
                                r_state <= ST_PREFETCH;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                end

                ST_PREFETCH: begin
                    if (!r_stb) begin
                        if (!ioctl_upload) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_stb <= 1'b1;
                            // Nothing on the bus yet: a request simply
                            // becomes the demand read.
                            if (ioctl_rd) begin
                                r_adr   <= w_rd_adr;
                                r_wait  <= 1'b1;
                                r_state <= ST_DEMAND;
                            end
                        end
                    end else if (w_done) begin
                        r_want <= 1'b0;
                        if (!ioctl_upload) begin
                            r_wait  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else if (r_want || (w_rd && w_rd_adr == r_adr)) begin
                            // The prefetched word is the one the HPS asked for.
                            r_wait <= 1'b0;
                            r_din  <= w_ack ? wb_dat_i : FILL;
                            if (w_ack) r_adr   <= r_adr + 22'd1;
                            else       r_state <= ST_IDLE;
                        end else begin
                            if (w_ack) begin
                                r_buf_data <= wb_dat_i;
                                r_buf_adr  <= r_adr;
                                r_buf_vld  <= 1'b1;
                            end else begin
                                r_buf_vld  <= 1'b0;
                            end
                            if (w_rd) begin
                                r_adr   <= w_rd_adr;
                                r_wait  <= 1'b1;
                                r_state <= ST_DEMAND;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end else if (w_rd && !r_wait) begin
                        r_wait <= 1'b1;
                        if (w_rd_adr == r_adr) begin
                            r_want <= 1'b1;
                        end else begin
                            r_req_adr <= w_rd_adr;
                            r_state   <= ST_PF_REDIRECT;
                        end
                    end
                end

                ST_PF_REDIRECT: begin
                    // The in-flight prefetch is never aborted; its data is dropped.
                    if (w_done) begin
                        if (!ioctl_upload) begin
                            r_wait  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_adr   <= r_req_adr;
                            r_state <= ST_DEMAND;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase

            if (!ioctl_upload || w_up_rise) r_buf_vld <= 1'b0;
        end
    end

    assign ioctl_din     = r_din;
    assign ioctl_wait    = r_wait;
    assign upload_active = r_active;
    assign wb_cyc        = r_stb;
    assign wb_stb        = r_stb;
    assign wb_we         = 1'b0;
    assign wb_sel        = WB_SEL_WORD;
    assign wb_cti        = WB_CTI_CLASSIC;
    assign wb_adr        = {2'b00, r_adr, 2'b00};
    assign timeout_err   = r_terr;

endmodule

// File: tb/tb_archie_ram_uploader.sv
// ----------------------------------------------------------------------------
// tb_archie_ram_uploader
// Directed bench for archie_ram_uploader (TIMEOUT=16). The wishbone slave is
// played inline by the stimulus sequence; expected values are hand-computed.
// ----------------------------------------------------------------------------
module tb_archie_ram_uploader;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_upload = 1'b1;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [31:0] ioctl_din;
    logic        ioctl_wait;
    logic        upload_active;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic [25:0] wb_adr;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack = 1'b0;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    logic seen_stb;

    archie_ram_uploader #(
        .PREFETCH (1'b1),
        .TIMEOUT  (16),
        .FILL     (32'hFFFF_FFFF)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ioctl_upload  (ioctl_upload),
        .ioctl_rd      (ioctl_rd),
        .ioctl_addr    (ioctl_addr),
        .ioctl_din     (ioctl_din),
        .ioctl_wait    (ioctl_wait),
        .upload_active (upload_active),
        .wb_cyc        (wb_cyc),
        .wb_stb        (wb_stb),
        .wb_we         (wb_we),
        .wb_sel        (wb_sel),
        .wb_cti        (wb_cti),
        .wb_adr        (wb_adr),
        .wb_dat_i      (wb_dat_i),
        .wb_ack        (wb_ack),
        .timeout_err   (timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic rd(input logic [24:0] a);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd   = 1'b0;
    endtask

    task automatic ack(input logic [31:0] d);
        wb_dat_i = d;
        wb_ack   = 1'b1;
        tick();
        wb_ack   = 1'b0;
        wb_dat_i = '0;
    endtask

    initial begin
        // Reset held 3 cycles with the session already open.
        seen_stb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen_stb = seen_stb | wb_stb;
        end
        check("rst_no_stb", {31'd0, seen_stb}, 32'd0);
        check("rst_din", ioctl_din, 32'd0);
        check("rst_wait", {31'd0, ioctl_wait}, 32'd0);
        check("rst_cyc", {31'd0, wb_cyc}, 32'd0);
        check("rst_adr", {6'd0, wb_adr}, 32'd0);
        check("rst_terr", {31'd0, timeout_err}, 32'd0);
        check("rst_active", {31'd0, upload_active}, 32'd0);
        check("const_we", {31'd0, wb_we}, 32'd0);
        check("const_sel", {28'd0, wb_sel}, 32'hF);
        check("const_cti", {29'd0, wb_cti}, 32'd0);
        reset = 1'b0;
        tick();
        check("active_after_rst", {31'd0, upload_active}, 32'd1);
        tick();

        // Miss at 0x100, ack on the 5th strobe cycle.
        rd(25'h000100);
        check("miss_stb", {31'd0, wb_stb}, 32'd1);
        check("miss_wait", {31'd0, ioctl_wait}, 32'd1);
        check("miss_adr", {6'd0, wb_adr}, 32'h100);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("miss_wait_hold", {31'd0, ioctl_wait}, 32'd1);
        end
        ack(32'h1234_5678);
        check("miss_din", ioctl_din, 32'h1234_5678);
        check("miss_wait_drop", {31'd0, ioctl_wait}, 32'd0);
        check("miss_stb_drop", {31'd0, wb_stb}, 32'd0);
        tick();
        check("pf_stb", {31'd0, wb_stb}, 32'd1);
        check("pf_adr", {6'd0, wb_adr}, 32'h104);

        // Sequential hit on the prefetched word.
        ack(32'hCAFE_F00D);
        check("pf_stb_drop", {31'd0, wb_stb}, 32'd0);
        check("pf_wait", {31'd0, ioctl_wait}, 32'd0);
        rd(25'h000104);
        check("hit_din", ioctl_din, 32'hCAFE_F00D);
        check("hit_wait", {31'd0, ioctl_wait}, 32'd0);
        check("hit_pf_stb", {31'd0, wb_stb}, 32'd1);
        check("hit_pf_adr", {6'd0, wb_adr}, 32'h108);

        // Redirect while the 0x108 prefetch is in flight.
        rd(25'h000400);
        check("redir_wait", {31'd0, ioctl_wait}, 32'd1);
        check("redir_adr_hold", {6'd0, wb_adr}, 32'h108);
        ack(32'hDEAD_BEEF);
        check("redir_gap", {31'd0, wb_stb}, 32'd0);
        check("redir_discard", ioctl_din, 32'hCAFE_F00D);
        check("redir_wait_hold", {31'd0, ioctl_wait}, 32'd1);
        tick();
        check("redir_stb", {31'd0, wb_stb}, 32'd1);
        check("redir_adr", {6'd0, wb_adr}, 32'h400);
        tick();
        ack(32'h0BAD_F00D);
        check("redir_din", ioctl_din, 32'h0BAD_F00D);
        check("redir_wait_drop", {31'd0, ioctl_wait}, 32'd0);
        tick();
        check("redir_pf_adr", {6'd0, wb_adr}, 32'h404);
        ack(32'h1111_1111);

        // Demand timeout: strobe held 16 cycles, then FILL.
        rd(25'h000800);
        check("tmo_stb", {31'd0, wb_stb}, 32'd1);
        for (int i = 0; i < 15; i++) tick();
        check("tmo_stb_16", {31'd0, wb_stb}, 32'd1);
        check("tmo_terr_pre", {31'd0, timeout_err}, 32'd0);
        tick();
        check("tmo_stb_drop", {31'd0, wb_stb}, 32'd0);
        check("tmo_din", ioctl_din, 32'hFFFF_FFFF);
        check("tmo_wait", {31'd0, ioctl_wait}, 32'd0);
        check("tmo_terr", {31'd0, timeout_err}, 32'd1);
        tick();
        check("tmo_terr_sticky", {31'd0, timeout_err}, 32'd1);

        // Session closes mid-demand: cycle completes, data discarded.
        rd(25'h000200);
        check("abort_stb", {31'd0, wb_stb}, 32'd1);
        ioctl_upload = 1'b0;
        tick();
        tick();
        check("abort_stb_hold", {31'd0, wb_stb}, 32'd1);
        ack(32'h5555_5555);
        check("abort_stb_drop", {31'd0, wb_stb}, 32'd0);
        check("abort_din", ioctl_din, 32'hFFFF_FFFF);
        check("abort_wait", {31'd0, ioctl_wait}, 32'd0);
        check("abort_active_lag", {31'd0, upload_active}, 32'd1);
        tick();
        check("abort_active", {31'd0, upload_active}, 32'd0);
        check("abort_buf_vld", {31'd0, dut.r_buf_vld}, 32'd0);
        rd(25'h000404);
        check("closed_rd_ignored", {31'd0, wb_stb}, 32'd0);

        // Reopen: timeout_err clears on the rising edge.
        ioctl_upload = 1'b1;
        tick();
        check("reopen_terr", {31'd0, timeout_err}, 32'd0);
        check("reopen_active", {31'd0, upload_active}, 32'd1);

        // Wrap: prefetch after the top word goes to address 0.
        rd(25'hFFFFFC);
        check("wrap_adr", {6'd0, wb_adr}, 32'hFFFFFC);
        check("wrap_wait", {31'd0, ioctl_wait}, 32'd1);
        ack(32'h7777_7777);
        check("wrap_din", ioctl_din, 32'h7777_7777);
        tick();
        check("wrap_pf_stb", {31'd0, wb_stb}, 32'd1);
        check("wrap_pf_adr", {6'd0, wb_adr}, 32'h0);
        ack(32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
